// File: rtl/lif_neuron.sv
// ============================================================================
//  Module  : lif_neuron
//  Brief   : Leaky integrate-and-fire membrane stage with refractory period.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module lif_neuron #(
    parameter int ACCWID     = 12,
    parameter int VWID       = 16,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int RWID       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid,
    input  logic [ACCWID-1:0] acc,
    output logic              acc_ready,
    output logic              acc_clr,
    input  logic [VWID-1:0]   vth,
    output logic              spike_valid,
    output logic              spike,
    output logic [VWID-1:0]   v,
    output logic              refr_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAK  = 2'd1,
        S_INTEG = 2'd2,
        S_FIRE  = 2'd3
    } state_t;

    localparam logic [RWID-1:0] c_refrac  = RWID'(REFRAC);
    localparam bit              c_leak_en = (LEAK_SHIFT != 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [VWID-1:0]     r_v;
    logic [ACCWID-1:0]   r_acc_q;
    logic [RWID-1:0]     r_refr_cnt;
    logic                r_acc_clr;
    logic                r_spike_valid;
    logic                r_spike;

    logic                w_accept;
    logic                w_refr_idle;
    logic [VWID-1:0]     w_leak_v;
    logic [VWID:0]       w_sum;
    logic [VWID-1:0]     w_sat_v;

    assign w_accept    = acc_valid && (r_state == S_IDLE);
    assign w_refr_idle = (r_refr_cnt == '0);
    // v - (v >> k) can never underflow, so no clamp is needed here
    assign w_leak_v    = r_v - (r_v >> LEAK_SHIFT);
    assign w_sum       = {1'b0, r_v} + {{(VWID + 1 - ACCWID){1'b0}}, r_acc_q};
    assign w_sat_v     = w_sum[VWID] ? {VWID{1'b1}} : w_sum[VWID-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (acc_valid) w_state_nxt = S_LEAK;
            S_LEAK:  w_state_nxt = S_INTEG;
            S_INTEG: w_state_nxt = S_FIRE;
            S_FIRE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_v           <= '0;
            r_acc_q       <= '0;
            r_refr_cnt    <= '0;
            r_acc_clr     <= 1'b0;
            r_spike_valid <= 1'b0;
            r_spike       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc_clr     <= w_accept;
            r_spike_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (acc_valid) r_acc_q <= acc;
                end
                S_LEAK: begin
                    if (w_refr_idle && c_leak_en) r_v <= w_leak_v;
                end
                S_INTEG: begin
                    if (w_refr_idle) r_v <= w_sat_v;
                end
                S_FIRE: begin
                    r_spike_valid <= 1'b1;
                    if (!w_refr_idle) begin
                        r_spike    <= 1'b0;
                        r_refr_cnt <= r_refr_cnt - 1'b1;
                    end else if (r_v >= vth) begin
                        r_spike    <= 1'b1;
                        r_v        <= '0;
                        r_refr_cnt <= c_refrac;
                    end else begin
                        r_spike    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc_ready   = (r_state == S_IDLE);
    assign acc_clr     = r_acc_clr;
    assign spike_valid = r_spike_valid;
    assign spike       = r_spike;
    assign v           = r_v;
    assign refr_active = !w_refr_idle;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron.sv
// ============================================================================
//  Module  : tb_lif_neuron
//  Brief   : Directed, table-driven self-checking bench for lif_neuron.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst;

    // default-parameter instance
    logic        acc_valid;
    logic [11:0] acc;
    logic        acc_ready, acc_clr, spike_valid, spike, refr_active;
    logic [15:0] vth, v;

    // LEAK_SHIFT=0, REFRAC=0 instance for saturation
    logic        acc_valid2;
    logic [11:0] acc2;
    logic        acc_ready2, acc_clr2, spike_valid2, spike2, refr_active2;
    logic [15:0] vth2, v2;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc(acc),
        .acc_ready(acc_ready), .acc_clr(acc_clr), .vth(vth),
        .spike_valid(spike_valid), .spike(spike), .v(v),
        .refr_active(refr_active)
    );

    lif_neuron #(.LEAK_SHIFT(0), .REFRAC(0)) dut_sat (
        .clk(clk), .rst(rst), .acc_valid(acc_valid2), .acc(acc2),
        .acc_ready(acc_ready2), .acc_clr(acc_clr2), .vth(vth2),
        .spike_valid(spike_valid2), .spike(spike2), .v(v2),
        .refr_active(refr_active2)
    );

    always @(posedge clk) begin
        if (!rst && acc_valid && acc_ready) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic [11:0] acc;
        logic [15:0] vth;
        bit          hold;
        bit          exp_spike;
        logic [15:0] exp_v;
        bit          exp_refr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_step(input vec_t r, input int idx);
        int lat;
        int hs0;
        string tag;
        tag = $sformatf("step%0d", idx);
        vth       = r.vth;
        acc       = r.acc;
        acc_valid = 1'b1;
        hs0       = hs_cnt;
        chk({tag, "_ready_idle"}, acc_ready, 1);
        @(posedge clk); #1;
        if (!r.hold) acc_valid = 1'b0;
        chk({tag, "_acc_clr_pulse"}, acc_clr, 1);
        chk({tag, "_busy_ready"}, acc_ready, 0);
        lat = 0;
        while (!spike_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (!spike_valid) begin
                chk({tag, "_acc_clr_low"}, acc_clr, 0);
                chk({tag, "_busy_ready"}, acc_ready, 0);
            end
        end
        acc_valid = 1'b0;
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_spike"}, spike, r.exp_spike);
        chk({tag, "_v"}, v, r.exp_v);
        chk({tag, "_refr_active"}, refr_active, r.exp_refr);
        chk({tag, "_ready_with_valid"}, acc_ready, 1);
        chk({tag, "_handshakes"}, hs_cnt - hs0, 1);
        @(posedge clk); #1;
        chk({tag, "_spike_valid_pulse"}, spike_valid, 0);
    endtask

    initial begin
        int cyc;
        logic [15:0] exp_v2;

        //          acc    vth  hold spike  v     refr
        vecs[0] = '{12'd40,   16'd100, 1'b0, 1'b0, 16'd0 + 16'd40, 1'b0};
        vecs[1] = '{12'd70,   16'd100, 1'b1, 1'b1, 16'd0,  1'b1}; // 40->35, +70 = 105
        vecs[2] = '{12'd4095, 16'd100, 1'b0, 1'b0, 16'd0,  1'b1}; // refr 2->1
        vecs[3] = '{12'd4095, 16'd100, 1'b0, 1'b0, 16'd0,  1'b0}; // refr 1->0
        vecs[4] = '{12'd100,  16'd100, 1'b0, 1'b1, 16'd0,  1'b1}; // v == vth fires
        vecs[5] = '{12'd0,    16'd0,   1'b0, 1'b0, 16'd0,  1'b1}; // refractory
        vecs[6] = '{12'd0,    16'd0,   1'b0, 1'b0, 16'd0,  1'b0};
        vecs[7] = '{12'd0,    16'd0,   1'b0, 1'b1, 16'd0,  1'b1}; // vth=0 always fires

        rst = 1'b1; acc_valid = 1'b0; acc = '0; vth = '0;
        acc_valid2 = 1'b0; acc2 = '0; vth2 = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_v", v, 0);
        chk("rst_acc_ready", acc_ready, 1);
        chk("rst_acc_clr", acc_clr, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_spike", spike, 0);
        chk("rst_refr_active", refr_active, 0);

        for (int i = 0; i < 8; i++) run_step(vecs[i], i);

        // Saturation: back-to-back 4095s with no leak and no refractory
        acc2 = 12'd4095; vth2 = 16'hFFFF; acc_valid2 = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (!spike_valid2 && cyc < 10);
            if (n == 17) acc_valid2 = 1'b0;
            chk($sformatf("sat%0d_timeout", n), (cyc < 10), 1);
            exp_v2 = (n < 17) ? 16'(4095 * n) : 16'd0;
            chk($sformatf("sat%0d_v", n), v2, exp_v2);
            chk($sformatf("sat%0d_spike", n), spike2, (n == 17));
        end
        @(posedge clk); #1;
        chk("sat_idle_after", acc_ready2, 1);

        // Reset in the middle of a timestep
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_step('{12'd50, 16'd1000, 1'b0, 1'b0, 16'd50, 1'b0}, 8);
        acc = 12'd30; vth = 16'd1000; acc_valid = 1'b1;
        @(posedge clk); #1;                // E0 -> LEAK
        acc_valid = 1'b0;
        @(posedge clk); #1;                // E1 -> INTEG
        chk("midrst_leaked_v", v, 44);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_v", v, 0);
        chk("midrst_ready", acc_ready, 1);
        chk("midrst_spike_valid", spike_valid, 0);
        chk("midrst_acc_clr", acc_clr, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("midrst_quiet_sv", spike_valid, 0);
            chk("midrst_quiet_clr", acc_clr, 0);
        end
        run_step('{12'd30, 16'd1000, 1'b0, 1'b0, 16'd30, 1'b0}, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
Leaky integrate-and-fire membrane stage that sits directly downstream of the synaptic accumulator. Once per timestep it accepts the accumulator's summed synaptic input and applies a shift-based leak to the membrane potential. It then adds the input, compares the result against a runtime threshold, emits a spike result and pulses a clear back to the accumulator. It also enforces a refractory period of a fixed number of timesteps after each spike.

Parameters:
ACCWID, 12, width of the incoming accumulated sum (must be <= VWID)
VWID, 16, membrane potential width (unsigned)
LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT subtracted each timestep; 0 disables leak
REFRAC, 2, timesteps suppressed after a spike (0 = none)
RWID, 4, refractory counter width (must hold REFRAC)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
acc_valid  input  1  accumulated sum for this timestep is available
acc  input  ACCWID  accumulated synaptic sum (unsigned)
acc_ready  output  1  block can accept acc this cycle
acc_clr  output  1  one-cycle pulse to clear the upstream accumulator
vth  input  VWID  firing threshold (sampled in FIRE state)
spike_valid  output  1  one-cycle pulse: timestep result available
spike  output  1  neuron fired this timestep (meaningful when spike_valid=1)
v  output  VWID  current membrane potential
refr_active  output  1  refractory counter nonzero

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, v=0, refr_cnt=0, acc_clr=0, spike_valid=0, spike=0, latched acc=0. Reset takes effect from any state, including mid-timestep. An interrupted timestep produces no spike_valid and no further acc_clr.
- States: IDLE -> LEAK -> INTEG -> FIRE -> IDLE. The path is fixed, with no early exits.
- acc_ready = (state==IDLE), combinational. A handshake occurs on an edge E0 with acc_valid && acc_ready. acc_valid held high while busy is ignored, not queued.
- Edge E0: acc latched to acc_q, state->LEAK. acc_clr is registered high for exactly the cycle after E0.
- LEAK (edge E1): if refr_cnt==0 and LEAK_SHIFT!=0, v <= v - (v >> LEAK_SHIFT), else v unchanged. The result is never negative. state->INTEG. acc_clr returns to 0.
- INTEG (edge E2): if refr_cnt==0, v <= min(v + zero-extended acc_q, 2^VWID-1), saturating with no wrap. Otherwise v unchanged and acc_q discarded. state->FIRE.
- FIRE (edge E3), state->IDLE, spike_valid<=1:
  - If refr_cnt!=0: spike<=0, refr_cnt<=refr_cnt-1.
  - Else if v >= vth: spike<=1, v<=0, refr_cnt<=REFRAC.
  - Else: spike<=0.
- spike_valid is high for exactly one cycle (cleared at E4). spike holds its value until the next FIRE.
- Latency: handshake edge to spike_valid high = 3 edges. acc_ready is high again in the same cycle as spike_valid, so a new acc may be accepted there, giving one timestep per 4 cycles at full rate.
- Comparison is inclusive (v == vth fires). vth=0 fires every non-refractory timestep.
- refr_active = (refr_cnt != 0).

Test Plan:
- Reset: hold rst 2 cycles -> v=0, acc_ready=1, acc_clr=0, spike_valid=0, refr_active=0.
- Sub-threshold (VWID=16, ACCWID=12, LEAK_SHIFT=3, REFRAC=2, vth=100): acc=40 accepted at E0 -> acc_clr=1 for one cycle after E0, acc_ready=0 for 3 cycles, spike_valid=1 with spike=0 after E3, v=40.
- Leak then fire: next acc=70 -> leak 40->35, sum 105 >= 100 -> spike=1, v=0, refr_active=1. Also hold acc_valid during busy and confirm it is accepted exactly once.
- Refractory and boundary: next two timesteps acc=4095 -> spike=0, v=0, refr_cnt 2->1->0. Third timestep acc=100 -> v=100 == vth -> spike=1.
- Saturation (LEAK_SHIFT=0, REFRAC=0, vth=65535): 16 timesteps of acc=4095 -> v=65520, spike=0. 17th -> v saturates at 65535 (no wrap), spike=1, v=0.
- Reset mid-op: v=50, assert rst for one edge while in INTEG -> next cycle state IDLE, v=0, no spike_valid pulse, no extra acc_clr. A subsequent acc=30 completes normally with v=30.
